// File: rtl/control_sequencer.sv
// control_sequencer: SAP-1.5 microcode sequencer; T-state counter plus
// combinational decode of step, opcode and flags into the control word.
module control_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       flag_zero,
    input  logic       flag_carry,
    output logic [2:0] step,
    output logic       halted,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       pc_oe,
    output logic       mar_load,
    output logic       ram_oe,
    output logic       ram_we,
    output logic       ir_load,
    output logic       ir_oe,
    output logic       a_load,
    output logic       a_oe,
    output logic       b_load,
    output logic       alu_sub,
    output logic       alu_oe,
    output logic       flags_load,
    output logic       out_load
);
    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [2:0] step_q, step_d;
    logic       halted_q, halted_d;
    logic       run, t0, t1, t2, t3, t4;
    logic       op_lda, op_add, op_sub, op_sta, op_ldi, op_jmp, op_jc, op_jz, op_out, op_hlt;
    logic       mem_op, alu_op, take_jump, last;

    assign op_lda = opcode == OP_LDA;
    assign op_add = opcode == OP_ADD;
    assign op_sub = opcode == OP_SUB;
    assign op_sta = opcode == OP_STA;
    assign op_ldi = opcode == OP_LDI;
    assign op_jmp = opcode == OP_JMP;
    assign op_jc  = opcode == OP_JC;
    assign op_jz  = opcode == OP_JZ;
    assign op_out = opcode == OP_OUT;
    assign op_hlt = opcode == OP_HLT;

    assign mem_op    = op_lda | op_add | op_sub | op_sta;
    assign alu_op    = op_add | op_sub;
    assign take_jump = op_jmp | (op_jc & flag_carry) | (op_jz & flag_zero);

    // Illegal steps 5-7 match no tN, so they decode to an all-zero word.
    assign run = !reset && !halted_q;
    assign t0  = run && step_q == T0;
    assign t1  = run && step_q == T1;
    assign t2  = run && step_q == T2;
    assign t3  = run && step_q == T3;
    assign t4  = run && step_q == T4;

    assign last = (step_q == T2 && !mem_op && !op_hlt) ||
                  (step_q == T3 && (op_lda || op_sta)) || step_q == T4;

    // HLT leaves step parked at T2 while the halt flag is set.
    assign halted_d = halted_q | (step_q == T2 && op_hlt);
    assign step_d   = halted_d ? step_q : (last || step_q > T4) ? T0 : step_q + 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    assign step       = step_q;
    assign halted     = halted_q && !reset;
    assign pc_oe      = t0;
    assign mar_load   = t0 | (t2 & mem_op);
    assign ram_oe     = t1 | (t3 & (op_lda | alu_op));
    assign ir_load    = t1;
    assign pc_inc     = t1;
    assign ir_oe      = t2 & (mem_op | op_ldi | take_jump);
    assign pc_load    = t2 & take_jump;
    assign a_load     = (t2 & op_ldi) | (t3 & op_lda) | (t4 & alu_op);
    assign a_oe       = (t2 & op_out) | (t3 & op_sta);
    assign ram_we     = t3 & op_sta;
    assign b_load     = t3 & alu_op;
    assign alu_sub    = (t3 | t4) & op_sub;
    assign alu_oe     = t4 & alu_op;
    assign flags_load = t4 & alu_op;
    assign out_load   = t2 & op_out;
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcode sequencer for the 8-bit SAP-1.5 CPU, downstream of the instruction register.
- Consumes the 4-bit opcode and the registered ALU flags. Runs a step counter (T-states) and decodes step, opcode and flags into the one-cycle control word that drives the PC, MAR, RAM, A, B, ALU, OUT and IR.
- Owns fetch, execute and halt sequencing.

Parameters:
- None. Opcode map and step timing are fixed by the ISA below.

Ports:
- clk        in   1  system clock, rising edge
- reset      in   1  synchronous, active-high reset
- opcode     in   4  instruction register opcode field; valid from T2
- flag_zero  in   1  registered zero flag
- flag_carry in   1  registered carry flag
- step       out  3  current T-state, debug
- halted     out  1  sticky halt indicator
- pc_inc     out  1  increment PC
- pc_load    out  1  load PC from bus
- pc_oe      out  1  PC drives bus
- mar_load   out  1  load MAR from bus
- ram_oe     out  1  RAM drives bus
- ram_we     out  1  write bus into RAM[MAR]
- ir_load    out  1  load IR from bus
- ir_oe      out  1  IR operand drives bus (zero-extended)
- a_load     out  1  load A
- a_oe       out  1  A drives bus
- b_load     out  1  load B
- alu_sub    out  1  ALU subtract select
- alu_oe     out  1  ALU result drives bus
- flags_load out  1  capture ALU flags
- out_load   out  1  load output register

Behaviour:
- State: step register (0..4) and halted flag. Both are updated only on the rising edge of clk.
- Control outputs are a combinational decode of step, halted, opcode and flags. Targets latch on the clock edge that ends the step.
- Reset (synchronous): step<=0, halted<=0.
  - While reset is high, every control output and halted is forced to 0.
  - step reads 0 after the first reset edge.
  - Reset mid-instruction aborts it; the next cycle after reset deasserts is T0 fetch.
- Fetch, common to all opcodes:
  - T0: pc_oe, mar_load.
  - T1: ram_oe, ir_load, pc_inc.
- Execute, per opcode:
  - 0x0 NOP: T2 no controls (last step).
  - 0x1 LDA: T2 ir_oe, mar_load. T3 ram_oe, a_load (last).
  - 0x2 ADD: T2 ir_oe, mar_load. T3 ram_oe, b_load. T4 alu_oe, a_load, flags_load (last).
  - 0x3 SUB: as ADD, with alu_sub asserted in T3 and T4.
  - 0x4 STA: T2 ir_oe, mar_load. T3 a_oe, ram_we (last).
  - 0x5 LDI: T2 ir_oe, a_load (last).
  - 0x6 JMP: T2 ir_oe, pc_load (last).
  - 0x7 JC: T2 ir_oe, pc_load only if flag_carry=1, else no controls (last).
  - 0x8 JZ: as JC, using flag_zero.
  - 0xE OUT: T2 a_oe, out_load (last).
  - 0xF HLT: T2 no controls. At the end of T2, halted<=1.
  - 0x9–0xD: reserved, execute as NOP.
- Step advance: at the edge ending a "last" step, step<=0; otherwise step<=step+1.
  - Instruction length therefore varies from 3 to 5 cycles.
  - step never exceeds 4. Any illegal value (5–7) returns to 0 on the next edge, with no controls asserted.
- Halt:
  - Once halted=1, step freezes at its current value and all control outputs are 0.
  - Halt persists until reset. No other input clears it.
- Bus exclusivity: at most one of pc_oe, ram_oe, ir_oe, a_oe, alu_oe is high in any cycle. Verification asserts this every cycle.
- Flags are sampled combinationally during T2 only. A flag change in other steps has no effect.

Test Plan:
- Reset held 3 cycles, then released with opcode=0x5 -> all controls 0 during reset. step 0,1,2,0 across the next 4 cycles, with pc_oe+mar_load at T0, ram_oe+ir_load+pc_inc at T1, ir_oe+a_load at T2.
- opcode=0x2, then 0x3 back-to-back -> 5-cycle instructions. alu_oe+a_load+flags_load at T4 both times. alu_sub=0 for ADD and 1 in T3/T4 for SUB. step returns to 0 after T4.
- opcode=0x7 with flag_carry=0, then again with flag_carry=1 -> first instruction has no pc_load in T2. Second asserts ir_oe+pc_load in T2. Both end at T2. Repeat for 0x8 with flag_zero.
- opcode=0x4 -> T3 asserts a_oe and ram_we, and ram_we is high in no other step. opcode=0xB -> behaves as NOP, 3 cycles, no execute controls.
- opcode=0xF -> halted=1 from the cycle after T2. step frozen at 2 and all controls 0 for 20 cycles despite opcode changes. Reset pulse -> halted=0, step=0, fetch resumes.
- Reset asserted during T3 of LDA -> a_load never asserted. After release, step=0 and T0 controls are present.
